count_dir_decoder: RTL
======================

COUNT_DIR_DECODER -- requirements
Module: count_dir_decoder

Interface
REQ-001 Parameter: WIDTH, 8, width of the observed count bus.
REQ-002 Parameter: LOCK_N, 2, consecutive same-direction steps required to acquire lock.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock, shared with the up/down counter under observation.
REQ-005 Port: reset  input  1  asynchronous, active-low (0 = reset).
REQ-006 Port: count_in  input  WIDTH  counter value, sampled on clk.
REQ-007 Port: valid  input  1  count_in is sampled only when valid=1.
REQ-008 Port: clr_turn  input  1  synchronous clear of turn_cnt.
REQ-009 Port: dir_out  output  1  recovered direction: 1=up, 0=down.
REQ-010 Port: locked  output  1  direction tracking is locked.
REQ-011 Port: turn  output  1  one-cycle pulse on a direction reversal while locked.
REQ-012 Port: wrap  output  1  one-cycle pulse on a modular wrap step.
REQ-013 Port: step_err  output  1  one-cycle pulse on an illegal step.
REQ-014 Port: turn_cnt  output  8  saturating count of reversals.

Function
REQ-015 All outputs SHALL be registered; the event for a sample is visible in the cycle after the edge that sampled it.
REQ-016 State: prev (WIDTH), have_prev, run counter, FSM {UNLOCKED, UP, DOWN}.
REQ-017 valid=0: no state change, all pulses 0.
REQ-018 First valid sample after reset SHALL load prev, set have_prev, and produce no event.
REQ-019 Step classification, modulo 2^WIDTH: count_in==prev+1 is an up step; count_in==prev-1 is a down step; count_in==prev is a hold; anything else is illegal.
REQ-020 prev SHALL update on every valid sample, including illegal samples.
REQ-021 Hold SHALL cause no state change and no pulse.
REQ-022 UNLOCKED: run increments on a step in the same direction as the previous step, and restarts at 1 on a step in the opposite direction.
REQ-023 UNLOCKED: when run reaches LOCK_N, go to UP/DOWN, set locked=1, set dir_out accordingly, and do not pulse turn.
REQ-024 UP: an up step stays in UP; a down step goes to DOWN, sets dir_out=0, pulses turn, and increments turn_cnt.
REQ-025 DOWN: the symmetric rule applies.
REQ-026 Illegal step in any state: pulse step_err, go to UNLOCKED, locked=0, run=0; dir_out holds its last value.
REQ-027 wrap SHALL pulse on an up step 2^WIDTH-1 -> 0 or a down step 0 -> 2^WIDTH-1, in any state; the wrap step is a normal step.
REQ-028 turn_cnt SHALL saturate at 255.
REQ-029 clr_turn=1 with no turn in the same cycle: turn_cnt=0.
REQ-030 clr_turn=1 with a turn in the same cycle: turn_cnt=1.
REQ-031 turn and wrap MAY pulse in the same cycle.
REQ-032 step_err SHALL never coincide with turn or wrap.

Reset
REQ-033 reset=0 SHALL immediately, without a clock edge, force: FSM=UNLOCKED, locked=0, dir_out=0, turn=0, wrap=0, step_err=0, turn_cnt=0, prev=0, have_prev=0, run=0.
REQ-034 Reset asserted mid-operation SHALL discard history; the first valid sample after release is treated per REQ-018.
REQ-035 Reset release is synchronous to clk in use; the block SHALL behave correctly from the first rising edge after release.

Verification
REQ-036 Lock: after reset, valid count 10,11,12,13 -> locked=1, dir_out=1 in the cycle after 12 is sampled; no turn, wrap or step_err.
REQ-037 Wrap: locked up, samples 254,255,0,1 -> wrap=1 for exactly one cycle after 0 is sampled; dir_out stays 1; locked stays 1.
REQ-038 Turn: locked up at 20, then 19,18 -> turn=1 for one cycle after 19; dir_out=0; turn_cnt 0->1; locked stays 1.
REQ-039 Error: locked, samples 40,45 -> step_err=1 for one cycle; locked=0; dir_out unchanged; then 46,47 -> relock with dir_out=1.
REQ-040 Saturation and clear: drive 256 reversals -> turn_cnt=255; then clr_turn with a simultaneous turn -> turn_cnt=1; clr_turn alone -> 0.
REQ-041 Reset mid-run: locked with turn_cnt=5, pull reset low between edges -> all outputs 0 immediately; after release, sample 100 -> no event; then 99,98 -> locked=1, dir_out=0.

Source files
------------

// File: rtl/count_dir_decoder_if.sv
// ============================================================================
// Module   : count_dir_decoder_if
// Brief    : Sample/result bundle between a count source and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface count_dir_decoder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] count_in;
  logic             valid;
  logic             clr_turn;
  logic             dir_out;
  logic             locked;
  logic             turn;
  logic             wrap;
  logic             step_err;
  logic [7:0]       turn_cnt;

  modport master (
    output count_in, valid, clr_turn,
    input  dir_out, locked, turn, wrap, step_err, turn_cnt
  );

  modport slave (
    input  count_in, valid, clr_turn,
    output dir_out, locked, turn, wrap, step_err, turn_cnt
  );
endinterface

`default_nettype wire

// File: rtl/count_dir_decoder.sv
// ============================================================================
// Module   : count_dir_decoder
// Brief    : Recovers count direction of an up/down counter from its samples.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module count_dir_decoder #(
  parameter int WIDTH  = 8,
  parameter int LOCK_N = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  count_dir_decoder_if.slave bus
);

  localparam int               c_RUN_W = $clog2(LOCK_N + 1);
  localparam logic [c_RUN_W-1:0] c_LOCK  = c_RUN_W'(LOCK_N);
  localparam logic [c_RUN_W-1:0] c_RUN1  = c_RUN_W'(1);
  localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_MAX   = '1;

  typedef enum logic [1:0] {
    S_UNLOCKED = 2'd0,
    S_UP       = 2'd1,
    S_DOWN     = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_prev;
  logic               r_have_prev;
  logic [c_RUN_W-1:0] r_run;
  logic               r_last_up;
  logic               r_dir;
  logic               r_locked;
  logic               r_turn;
  logic               r_wrap;
  logic               r_err;
  logic [7:0]         r_turn_cnt;

  logic               w_sample;
  logic               w_up;
  logic               w_down;
  logic               w_hold;
  logic               w_illegal;
  logic               w_wrap_step;
  logic               w_turn;
  logic [c_RUN_W-1:0] w_run_next;

  // Only a sample with a predecessor can be classified as a step.
  assign w_sample    = bus.valid && r_have_prev;
  assign w_up        = (bus.count_in == (r_prev + c_ONE));
  assign w_down      = (bus.count_in == (r_prev - c_ONE));
  assign w_hold      = (bus.count_in == r_prev);
  assign w_illegal   = w_sample && !w_up && !w_down && !w_hold;
  assign w_wrap_step = (w_up && (r_prev == c_MAX)) || (w_down && (r_prev == '0));
  assign w_turn      = w_sample && (((r_state == S_UP) && w_down) ||
                                    ((r_state == S_DOWN) && w_up));
  assign w_run_next  = ((r_run != '0) && (w_up == r_last_up)) ? (r_run + c_RUN1) : c_RUN1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_UNLOCKED;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_run       <= '0;
      r_last_up   <= 1'b0;
      r_dir       <= 1'b0;
      r_locked    <= 1'b0;
      r_turn      <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_turn_cnt  <= 8'd0;
    end else begin
      r_turn <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;

      // A clear coinciding with a turn keeps that turn counted.
      if (bus.clr_turn) begin
        r_turn_cnt <= w_turn ? 8'd1 : 8'd0;
      end else if (w_turn && (r_turn_cnt != 8'hFF)) begin
        r_turn_cnt <= r_turn_cnt + 8'd1;
      end

      if (bus.valid) begin
        r_prev      <= bus.count_in;
        r_have_prev <= 1'b1;
        if (w_illegal) begin
          r_err    <= 1'b1;
          r_state  <= S_UNLOCKED;
          r_locked <= 1'b0;
          r_run    <= '0;
        end else if (w_sample && !w_hold) begin
          r_wrap <= w_wrap_step;
          case (r_state)
            S_UNLOCKED: begin
              r_run     <= w_run_next;
              r_last_up <= w_up;
              if (w_run_next >= c_LOCK) begin
                r_state  <= w_up ? S_UP : S_DOWN;
                r_locked <= 1'b1;
                r_dir    <= w_up;
              end
            end
            S_UP: begin
              if (w_down) begin
                r_state <= S_DOWN;
                r_dir   <= 1'b0;
                r_turn  <= 1'b1;
              end
            end
            S_DOWN: begin
              if (w_up) begin
                r_state <= S_UP;
                r_dir   <= 1'b1;
                r_turn  <= 1'b1;
              end
            end
            default: begin
              r_state  <= S_UNLOCKED;
              r_locked <= 1'b0;
              r_run    <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.dir_out  = r_dir;
  assign bus.locked   = r_locked;
  assign bus.turn     = r_turn;
  assign bus.wrap     = r_wrap;
  assign bus.step_err = r_err;
  assign bus.turn_cnt = r_turn_cnt;

endmodule

`default_nettype wire
